// File: rtl/perf_meas_window.sv
// perf_meas_window
//   Windowed throughput counter for a valid/ready link. Every window of
//   win_len cycles yields one record {cycles, beats, stalls, dropped}.
//   Windows run back-to-back. One report slot absorbs consumer
//   backpressure. A record that finds the slot full is discarded and
//   counted in the next record's dropped field.
//
//   Optional feature macro: PERF_MEAS_WINDOW_STALL_EN
//     defined   : the stall counter is built and rpt_stalls counts
//                 mon_valid && !mon_ready cycles.
//     undefined : there is no stall counter. rpt_stalls is tied to 0 and
//                 the port list is unchanged.
//
//   Ports
//     clk         clock
//     reset       asynchronous, active-high reset
//     window      window length in cycles (0 = disabled), sampled at window start
//     mon_valid   monitored link valid
//     mon_ready   monitored link ready
//     rpt_valid   report slot holds a record
//     rpt_ready   consumer accepts the record
//     rpt_cycles  cycles in the reported window
//     rpt_beats   beats in the window (saturating)
//     rpt_stalls  stall cycles in the window (saturating, 0 when feature off)
//     rpt_dropped windows discarded since the previous loaded record
//     busy        measurement in progress (state COUNT)
module perf_meas_window #(
  parameter int WINDOW_W = 32,
  parameter int CNT_W    = 32,
  parameter int DROP_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WINDOW_W-1:0] window,
  input  logic                mon_valid,
  input  logic                mon_ready,
  output logic                rpt_valid,
  input  logic                rpt_ready,
  output logic [WINDOW_W-1:0] rpt_cycles,
  output logic [CNT_W-1:0]    rpt_beats,
  output logic [CNT_W-1:0]    rpt_stalls,
  output logic [DROP_W-1:0]   rpt_dropped,
  output logic                busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_t;

  localparam logic [WINDOW_W-1:0] WIN_ONE  = {{(WINDOW_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_W-1:0]   DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  // Saturating increment for the beat/stall counters.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] val,
                                                   input logic            inc);
    if (inc && (val != {CNT_W{1'b1}})) begin
      return val + CNT_ONE;
    end else begin
      return val;
    end
  endfunction

  // Saturating increment for the dropped-window counter.
  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] val);
    if (val != {DROP_W{1'b1}}) begin
      return val + DROP_ONE;
    end else begin
      return val;
    end
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [WINDOW_W-1:0] win_len_r;
  logic [WINDOW_W-1:0] cyc_r;
  logic [CNT_W-1:0]    beats_r;
  logic [DROP_W-1:0]   drop_cnt_r;

  logic                rpt_valid_r;
  logic [WINDOW_W-1:0] rpt_cycles_r;
  logic [CNT_W-1:0]    rpt_beats_r;
  logic [DROP_W-1:0]   rpt_dropped_r;
  logic                busy_s;

  logic                beat_s;
  logic                win_nz_s;
  logic                start_s;
  logic                eow_s;
  logic                hs_s;
  logic                load_s;
  logic                drop_s;
  logic [WINDOW_W-1:0] cyc_cand_s;
  logic [CNT_W-1:0]    beats_cand_s;

  assign beat_s   = mon_valid & mon_ready;
  assign win_nz_s = (window != {WINDOW_W{1'b0}});
  assign start_s  = (state_r == IDLE) && win_nz_s;
  // win_len_r is never 0 while in COUNT, so the subtraction cannot wrap.
  assign eow_s    = (state_r == COUNT) && (cyc_r == (win_len_r - WIN_ONE));
  assign hs_s     = rpt_valid_r & rpt_ready;
  // A handshake in the same cycle frees the slot for the new candidate.
  assign load_s   = eow_s & (~rpt_valid_r | rpt_ready);
  assign drop_s   = eow_s & rpt_valid_r & ~rpt_ready;

  // cyc_r <= win_len_r - 1, so cyc_r + 1 always fits in WINDOW_W bits.
  assign cyc_cand_s   = cyc_r + WIN_ONE;
  assign beats_cand_s = sat_inc_cnt(beats_r, beat_s);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic: window is re-sampled only at window boundaries.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_nz_s) begin
          state_next_s = COUNT;
        end else begin
          state_next_s = IDLE;
        end
      end
      COUNT: begin
        if (eow_s && !win_nz_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = COUNT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM output logic.
  always_comb begin
    busy_s = 1'b0;
    if (state_r == COUNT) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Window length latch plus cycle and beat counters, restarting at each boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_len_r <= '0;
      cyc_r     <= '0;
      beats_r   <= '0;
    end else if (start_s || eow_s) begin
      // A zero latched at the final boundary is harmless: the FSM goes to IDLE.
      win_len_r <= window;
      cyc_r     <= '0;
      beats_r   <= '0;
    end else if (state_r == COUNT) begin
      cyc_r   <= cyc_cand_s;
      beats_r <= beats_cand_s;
    end
  end

  // Dropped-window counter: cleared when a record loads, bumped when one is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_r <= '0;
    end else if (load_s) begin
      drop_cnt_r <= '0;
    end else if (drop_s) begin
      drop_cnt_r <= sat_inc_drop(drop_cnt_r);
    end
  end

  // Report slot: load at the window boundary if free, else clear the valid flag on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_valid_r   <= 1'b0;
      rpt_cycles_r  <= '0;
      rpt_beats_r   <= '0;
      rpt_dropped_r <= '0;
    end else if (load_s) begin
      rpt_valid_r   <= 1'b1;
      rpt_cycles_r  <= cyc_cand_s;
      rpt_beats_r   <= beats_cand_s;
      rpt_dropped_r <= drop_cnt_r;
    end else if (hs_s) begin
      rpt_valid_r <= 1'b0;
    end
  end

`ifdef PERF_MEAS_WINDOW_STALL_EN
  logic             stall_s;
  logic [CNT_W-1:0] stalls_r;
  logic [CNT_W-1:0] stalls_cand_s;
  logic [CNT_W-1:0] rpt_stalls_r;

  assign stall_s       = mon_valid & ~mon_ready;
  assign stalls_cand_s = sat_inc_cnt(stalls_r, stall_s);

  // Stall counter, restarting on the same boundaries as the beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stalls_r <= '0;
    end else if (start_s || eow_s) begin
      stalls_r <= '0;
    end else if (state_r == COUNT) begin
      stalls_r <= stalls_cand_s;
    end
  end

  // Stall field of the report slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_stalls_r <= '0;
    end else if (load_s) begin
      rpt_stalls_r <= stalls_cand_s;
    end
  end

  assign rpt_stalls = rpt_stalls_r;
`else
  assign rpt_stalls = {CNT_W{1'b0}};
`endif

  assign rpt_valid   = rpt_valid_r;
  assign rpt_cycles  = rpt_cycles_r;
  assign rpt_beats   = rpt_beats_r;
  assign rpt_dropped = rpt_dropped_r;
  assign busy        = busy_s;

endmodule

// File: tb/tb_perf_meas_window.sv
// Testbench for perf_meas_window. The main instance uses the default
// widths. A second instance with CNT_W=4 and DROP_W=2 exercises saturation.
// Expected records for the main instance go into a scoreboard queue when
// stimulus is driven. They are popped and compared when a report handshake
// is seen.
module tb_perf_meas_window;

`ifdef PERF_MEAS_WINDOW_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] cycles;
    logic [31:0] beats;
    logic [31:0] stalls;
    logic [15:0] dropped;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] window;
  logic        mon_valid, mon_ready, rpt_ready;
  logic        rpt_valid, busy;
  logic [31:0] rpt_cycles, rpt_beats, rpt_stalls;
  logic [15:0] rpt_dropped;

  logic [31:0] s_window;
  logic        s_mon_valid, s_mon_ready, s_rpt_ready;
  logic        s_rpt_valid, s_busy;
  logic [31:0] s_rpt_cycles;
  logic [3:0]  s_rpt_beats, s_rpt_stalls;
  logic [1:0]  s_rpt_dropped;

  int   check_cnt = 0;
  int   err_cnt   = 0;
  rec_t sb_q[$];
  rec_t exp_rec;

  always #5 clk = ~clk;

  perf_meas_window dut (
    .clk(clk), .reset(reset), .window(window),
    .mon_valid(mon_valid), .mon_ready(mon_ready),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_cycles(rpt_cycles), .rpt_beats(rpt_beats), .rpt_stalls(rpt_stalls),
    .rpt_dropped(rpt_dropped), .busy(busy)
  );

  perf_meas_window #(.WINDOW_W(32), .CNT_W(4), .DROP_W(2)) dut_sat (
    .clk(clk), .reset(reset), .window(s_window),
    .mon_valid(s_mon_valid), .mon_ready(s_mon_ready),
    .rpt_valid(s_rpt_valid), .rpt_ready(s_rpt_ready),
    .rpt_cycles(s_rpt_cycles), .rpt_beats(s_rpt_beats), .rpt_stalls(s_rpt_stalls),
    .rpt_dropped(s_rpt_dropped), .busy(s_busy)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_rec(input int c, input int b, input int s, input int d);
    rec_t r;
    r.cycles  = c;
    r.beats   = b;
    r.stalls  = s;
    r.dropped = d[15:0];
    sb_q.push_back(r);
  endtask

  // Inputs change 1 time unit after the rising edge. Outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: a handshake at the next rising edge consumes the record.
  always @(negedge clk) begin
    if (!reset && rpt_valid && rpt_ready) begin
      if (sb_q.size() == 0) begin
        check_val("rec_unexpected", 64'd1, 64'd0);
      end else begin
        exp_rec = sb_q.pop_front();
        check_val("rec_cycles",  rpt_cycles,  exp_rec.cycles);
        check_val("rec_beats",   rpt_beats,   exp_rec.beats);
        check_val("rec_stalls",  rpt_stalls,  exp_rec.stalls);
        check_val("rec_dropped", rpt_dropped, exp_rec.dropped);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    window = 32'd0; mon_valid = 1'b0; mon_ready = 1'b0; rpt_ready = 1'b0;
    s_window = 32'd0; s_mon_valid = 1'b0; s_mon_ready = 1'b0; s_rpt_ready = 1'b0;
    idle_ticks(3);
    reset = 1'b0;
    idle_ticks(2);

    // Reset state
    check_val("rst_valid",   rpt_valid,   1'b0);
    check_val("rst_cycles",  rpt_cycles,  32'd0);
    check_val("rst_beats",   rpt_beats,   32'd0);
    check_val("rst_stalls",  rpt_stalls,  32'd0);
    check_val("rst_dropped", rpt_dropped, 16'd0);
    check_val("rst_busy",    busy,        1'b0);

    // Steady traffic, window=4: first record 5 edges later, then one every 4
    window = 32'd4; mon_valid = 1'b1; mon_ready = 1'b1; rpt_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_rec(4, 4, 0, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (rpt_valid && lat == 0) lat = k;
      if (k == 2) check_val("t1_busy", busy, 1'b1);
      if (k == 10) window = 32'd0;
    end
    check_val("t1_latency", lat, 5);
    check_val("t1_busy_end", busy, 1'b0);
    check_val("t1_sb_empty", sb_q.size(), 0);

    // Alternating ready: two beats and two stalls per 4-cycle window
    window = 32'd4; mon_valid = 1'b1; mon_ready = 1'b1;
    for (int i = 0; i < 2; i++) push_rec(4, 2, STALL_EN ? 2 : 0, 0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      mon_ready = ~mon_ready;
      if (k == 6) window = 32'd0;
    end
    check_val("t2_sb_empty", sb_q.size(), 0);

    // Backpressure and drops: window=2, slot held, two windows dropped
    window = 32'd2; mon_valid = 1'b1; mon_ready = 1'b1; rpt_ready = 1'b0;
    push_rec(2, 2, 0, 0);
    push_rec(2, 2, 0, 2);
    push_rec(2, 2, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k >= 4 && k <= 8) begin
        check_val("t3_hold_valid",   rpt_valid,   1'b1);
        check_val("t3_hold_cycles",  rpt_cycles,  32'd2);
        check_val("t3_hold_dropped", rpt_dropped, 16'd0);
      end
      if (k == 8) rpt_ready = 1'b1;
      if (k == 10) window = 32'd0;
    end
    check_val("t3_sb_empty", sb_q.size(), 0);

    // Window of 1 with mon_valid held and mon_ready low: every cycle a stall
    window = 32'd1; mon_valid = 1'b1; mon_ready = 1'b0; rpt_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_rec(1, 0, STALL_EN ? 1 : 0, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) window = 32'd0;
    end
    check_val("t6_busy", busy, 1'b0);
    check_val("t6_sb_empty", sb_q.size(), 0);

    // Disable mid-window: current 8-cycle window still completes
    window = 32'd8; mon_valid = 1'b1; mon_ready = 1'b1; rpt_ready = 1'b1;
    push_rec(8, 8, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3) window = 32'd0;
      if (k == 5) check_val("t4_busy_mid", busy, 1'b1);
      if (k == 11) check_val("t4_busy_idle", busy, 1'b0);
    end
    check_val("t4_sb_empty", sb_q.size(), 0);

    // Reset mid-window while a record is pending
    window = 32'd8; mon_valid = 1'b1; mon_ready = 1'b1; rpt_ready = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 9) begin
        check_val("t5_pend_valid", rpt_valid, 1'b1);
        check_val("t5_pend_beats", rpt_beats, 32'd8);
      end
    end
    reset = 1'b1;
    #1;
    check_val("t5_valid",   rpt_valid,   1'b0);
    check_val("t5_cycles",  rpt_cycles,  32'd0);
    check_val("t5_beats",   rpt_beats,   32'd0);
    check_val("t5_dropped", rpt_dropped, 16'd0);
    check_val("t5_busy",    busy,        1'b0);
    window = 32'd0;
    tick();
    reset = 1'b0;
    idle_ticks(4);
    check_val("t5_after_busy",  busy,      1'b0);
    check_val("t5_after_valid", rpt_valid, 1'b0);

    // Beat saturation at CNT_W=4: window=20, continuous beats
    s_window = 32'd20; s_mon_valid = 1'b1; s_mon_ready = 1'b1; s_rpt_ready = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick();
      if (k == 5) s_window = 32'd0;
      if (s_rpt_valid) lat = k;
    end
    check_val("t7_latency", lat, 21);
    check_val("t7_cycles",  s_rpt_cycles,  32'd20);
    check_val("t7_beats",   s_rpt_beats,   4'd15);
    check_val("t7_dropped", s_rpt_dropped, 2'd0);
    idle_ticks(3);

    // Dropped counter saturation at DROP_W=2: five drops report as 3
    s_rpt_ready = 1'b0; s_window = 32'd1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) begin
        check_val("t8_first_valid",   s_rpt_valid,   1'b1);
        check_val("t8_first_dropped", s_rpt_dropped, 2'd0);
      end
    end
    s_rpt_ready = 1'b1; s_window = 32'd0;
    tick();
    check_val("t8_sat_dropped", s_rpt_dropped, 2'd3);
    check_val("t8_sat_cycles",  s_rpt_cycles,  32'd1);
    check_val("t8_sat_beats",   s_rpt_beats,   4'd1);
    tick();
    check_val("t8_busy", s_busy, 1'b0);
    idle_ticks(2);

    $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
    $finish;
  end

endmodule
